reg_scoreboard: RTL
===================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter DEPTH, default 4, maximum number of in-flight register writes tracked.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 dec_valid  input  1  decode stage holds a valid instruction.
REQ-005 dec_rs1, dec_rs2  input  5 each  source register indices.
REQ-006 dec_uses_rs1, dec_uses_rs2  input  1 each  the source is actually read.
REQ-007 dec_regwrite  input  1  instruction writes dec_rd.
REQ-008 dec_rd  input  5  destination register index.
REQ-009 flush  input  1  pipeline flush; discards all tracked writes.
REQ-010 wb_valid  input  1  a tracked write retires this cycle.
REQ-011 wb_rd  input  5  destination index of the retiring write.
REQ-012 dec_stall  output  1  combinational; holds decode this cycle.
REQ-013 busy_map  output  32  registered; bit n set iff register n has an in-flight write.
REQ-014 inflight_cnt  output  $clog2(DEPTH)+1  registered occupancy.
REQ-015 wb_err  output  1  registered one-cycle pulse on an illegal retire.

Function
REQ-016 Writes SHALL be tracked in an in-order FIFO of rd indices; head = oldest.
REQ-017 issue_fire = dec_valid & ~dec_stall; push = issue_fire & dec_regwrite & (dec_rd != 0).
REQ-018 pop = wb_valid & (inflight_cnt != 0) & (wb_rd == head rd).
REQ-019 wb_valid with an empty FIFO or wb_rd != head rd SHALL cause no pop and SHALL pulse wb_err the next cycle.
REQ-020 RAW: dec_stall SHALL assert when dec_valid and a used source is nonzero and matches any valid entry, except when the only matching entry is the head being popped in the same cycle (forwarding covers it).
REQ-021 Full: dec_stall SHALL assert when dec_valid & dec_regwrite & dec_rd != 0 and inflight_cnt == DEPTH, even if a pop occurs that cycle.
REQ-022 dec_stall SHALL be 0 whenever dec_valid = 0.
REQ-023 Simultaneous push and pop SHALL leave inflight_cnt unchanged and advance both pointers.
REQ-024 Pointers SHALL wrap modulo DEPTH; inflight_cnt SHALL never exceed DEPTH or underflow.
REQ-025 WAW duplicates SHALL be allowed; busy_map bit n SHALL stay set while any entry holds n.
REQ-026 busy_map and inflight_cnt SHALL reflect a push or pop the cycle after the edge on which it occurs (one-cycle latency).
REQ-027 flush SHALL empty the FIFO at the next edge, with priority over push and pop in the same cycle; wb_err SHALL NOT pulse in a flush cycle.
REQ-028 Register x0 SHALL never be tracked, stalled on, or set in busy_map.

Reset
REQ-029 rst SHALL asynchronously clear the pointers, inflight_cnt, all entry valids, busy_map and wb_err to 0.
REQ-030 A reset asserted mid-operation SHALL discard all in-flight entries; dec_stall SHALL be 0 while rst is high.

Structure
REQ-031 A shared package SHALL hold DEPTH default, REG_IDX_W = 5, NUM_REGS = 32, and the count width function.
REQ-032 The FIFO SHALL be one sub-module, sb_fifo (push, pop, flush, per-entry rd/valid vectors exposed for compare); reg_scoreboard holds the compare, stall and error logic.

Verification
REQ-033 Scenarios (one line each):
- Reset with dec_valid=1, rs1=5 -> dec_stall=0, busy_map=0, inflight_cnt=0.
- Push rd=5; next cycle dec rs1=5 used -> dec_stall=1, busy_map[5]=1; wb rd=5 same cycle -> dec_stall=0, bit cleared next cycle.
- Push rd=1,2,3,4 (DEPTH=4), then a regwrite to rd=6 -> dec_stall=1, inflight_cnt=4; non-writing instruction with unrelated sources -> dec_stall=0.
- Full FIFO, wb rd=1 with push attempt rd=7 -> push blocked, inflight_cnt=3 next cycle; next cycle push succeeds, cnt=4, pointers wrap.
- Entries rd=3,4; wb rd=4 -> wb_err pulses one cycle, cnt stays 2; wb on an empty FIFO -> wb_err pulse, cnt stays 0.
- Two entries rd=9,9 with flush and wb rd=9 in the same cycle -> cnt=0, busy_map=0, wb_err=0; an async rst pulse mid-cycle clears all state immediately.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register scoreboard: register-file geometry,
// the default tracking depth, the retire classification used by the top,
// and the width helpers that size the occupancy counter and FIFO pointers.
package reg_scoreboard_pkg;

   localparam int DEFAULT_DEPTH = 4;
   localparam int REG_IDX_W     = 5;
   localparam int NUM_REGS      = 32;

   // Classification of what the writeback port is doing this cycle.
   typedef enum logic [1:0] {
      WB_IDLE,
      WB_RETIRE,
      WB_ILLEGAL
   } wbAction_e;

   // Occupancy counter must be able to hold the value DEPTH itself.
   function automatic int cntWidth(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Pointer width; a single-entry FIFO still needs a one-bit pointer.
   function automatic int ptrWidth(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/sb_fifo.sv
// In-order FIFO of destination register indices for the scoreboard.
// The head is the oldest in-flight write. Every slot's rd and valid bit are
// exposed so the parent can compare decode sources against all of them.
module sb_fifo
   import reg_scoreboard_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic [REG_IDX_W-1:0]          pushRd,
   input  logic                          pop,
   input  logic                          flush,
   output logic [cntWidth(DEPTH)-1:0]    count,
   output logic [ptrWidth(DEPTH)-1:0]    headPtr,
   output logic [REG_IDX_W-1:0]          headRd,
   output logic [DEPTH*REG_IDX_W-1:0]    entryRd,
   output logic [DEPTH-1:0]              entryValid
);

   localparam int CNT_W = cntWidth(DEPTH);
   localparam int PTR_W = ptrWidth(DEPTH);

   logic [REG_IDX_W-1:0] rdMem [DEPTH];
   logic [PTR_W-1:0]     tailPtr;
   logic                 doPush;
   logic                 doPop;

   // Pointers step through 0..DEPTH-1 and wrap, so DEPTH need not be a
   // power of two.
   function automatic logic [PTR_W-1:0] advance(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Guard the requests locally as well as in the parent: a push into a full
   // FIFO or a pop from an empty one is ignored, so the count can never
   // exceed DEPTH or underflow regardless of what the caller asks for.
   always_comb begin
      doPush = push && (count != CNT_W'(DEPTH));
      doPop  = pop && (count != '0);
   end

   // Control state: pointers, occupancy and per-slot valid bits. Flush wins
   // over any push or pop in the same cycle and empties the FIFO outright.
   // A simultaneous push and pop moves both pointers and leaves the count
   // unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         headPtr    <= '0;
         tailPtr    <= '0;
         count      <= '0;
         entryValid <= '0;
      end else if (flush) begin
         headPtr    <= '0;
         tailPtr    <= '0;
         count      <= '0;
         entryValid <= '0;
      end else begin
         if (doPush) begin
            entryValid[tailPtr] <= 1'b1;
            tailPtr             <= advance(tailPtr);
         end
         if (doPop) begin
            entryValid[headPtr] <= 1'b0;
            headPtr             <= advance(headPtr);
         end
         count <= count + CNT_W'(doPush) - CNT_W'(doPop);
      end
   end

   // Index storage needs no reset: a slot's contents only matter while its
   // valid bit is set, and the valid bits are cleared by reset and flush.
   always_ff @(posedge clk) begin
      if (doPush && !flush) begin
         rdMem[tailPtr] <= pushRd;
      end
   end

   // Present the oldest entry and a flattened view of all slots for the
   // parent's hazard compare.
   always_comb begin
      entryRd = '0;
      for (int i = 0; i < DEPTH; i++) begin
         entryRd[i*REG_IDX_W +: REG_IDX_W] = rdMem[i];
      end
      headRd = rdMem[headPtr];
   end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard for an in-order pipeline. Tracks destination
// registers of issued-but-not-retired writes, stalls decode on RAW hazards
// or when tracking capacity is exhausted, and flags out-of-order or
// spurious writebacks.
module reg_scoreboard
   import reg_scoreboard_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        dec_valid,
   input  logic [REG_IDX_W-1:0]        dec_rs1,
   input  logic [REG_IDX_W-1:0]        dec_rs2,
   input  logic                        dec_uses_rs1,
   input  logic                        dec_uses_rs2,
   input  logic                        dec_regwrite,
   input  logic [REG_IDX_W-1:0]        dec_rd,
   input  logic                        flush,
   input  logic                        wb_valid,
   input  logic [REG_IDX_W-1:0]        wb_rd,
   output logic                        dec_stall,
   output logic [NUM_REGS-1:0]         busy_map,
   output logic [cntWidth(DEPTH)-1:0]  inflight_cnt,
   output logic                        wb_err
);

   localparam int CNT_W = cntWidth(DEPTH);
   localparam int PTR_W = ptrWidth(DEPTH);

   logic [CNT_W-1:0]           fifoCount;
   logic [PTR_W-1:0]           headPtr;
   logic [REG_IDX_W-1:0]       headRd;
   logic [DEPTH*REG_IDX_W-1:0] entryRd;
   logic [DEPTH-1:0]           entryValid;

   wbAction_e                  wbAction;
   logic                       doPop;
   logic                       doPush;
   logic                       issueFire;
   logic                       rawHazard;
   logic                       fullHazard;
   logic [NUM_REGS-1:0]        nextBusy;

   sb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (doPush),
      .pushRd     (dec_rd),
      .pop        (doPop),
      .flush      (flush),
      .count      (fifoCount),
      .headPtr    (headPtr),
      .headRd     (headRd),
      .entryRd    (entryRd),
      .entryValid (entryValid)
   );

   assign inflight_cnt = fifoCount;

   // Writes must retire in issue order, so a writeback is only legal when
   // it names the oldest tracked entry. Anything else, including a
   // writeback with nothing in flight, is classified as illegal and does
   // not touch the FIFO.
   always_comb begin
      wbAction = WB_IDLE;
      if (wb_valid) begin
         if ((fifoCount != '0) && (wb_rd == headRd)) begin
            wbAction = WB_RETIRE;
         end else begin
            wbAction = WB_ILLEGAL;
         end
      end
      doPop = (wbAction == WB_RETIRE);
   end

   // Decode stall. A used, nonzero source that matches any live entry is a
   // RAW hazard; the head being retired this very cycle does not count
   // because its result is forwarded. A writing instruction also stalls
   // when every tracking slot is taken, even if one frees up this cycle,
   // which keeps push and pop from ever landing on the same slot. Nothing
   // stalls while decode is idle or the block is in reset.
   always_comb begin
      rawHazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entryValid[i] && !(doPop && (headPtr == PTR_W'(i)))) begin
            if (dec_uses_rs1 && (dec_rs1 != '0) &&
                (dec_rs1 == entryRd[i*REG_IDX_W +: REG_IDX_W])) begin
               rawHazard = 1'b1;
            end
            if (dec_uses_rs2 && (dec_rs2 != '0) &&
                (dec_rs2 == entryRd[i*REG_IDX_W +: REG_IDX_W])) begin
               rawHazard = 1'b1;
            end
         end
      end
      fullHazard = dec_regwrite && (dec_rd != '0) && (fifoCount == CNT_W'(DEPTH));
      dec_stall  = !rst && dec_valid && (rawHazard || fullHazard);
      issueFire  = dec_valid && !dec_stall;
      doPush     = issueFire && dec_regwrite && (dec_rd != '0);
   end

   // Busy map as it will look after this edge: every live entry that is not
   // being retired, plus the one being issued. Duplicate destinations keep
   // their bit set until the last copy leaves. x0 is never marked, and a
   // flush empties everything.
   always_comb begin
      nextBusy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entryValid[i] && !(doPop && (headPtr == PTR_W'(i)))) begin
            nextBusy[entryRd[i*REG_IDX_W +: REG_IDX_W]] = 1'b1;
         end
      end
      if (doPush) begin
         nextBusy[dec_rd] = 1'b1;
      end
      nextBusy[0] = 1'b0;
      if (flush) begin
         nextBusy = '0;
      end
   end

   // Registered status outputs. The error pulse lasts exactly one cycle
   // after an illegal writeback and is suppressed when a flush is
   // discarding the pipeline anyway.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_map <= '0;
         wb_err   <= 1'b0;
      end else begin
         busy_map <= nextBusy;
         wb_err   <= (wbAction == WB_ILLEGAL) && !flush;
      end
   end

endmodule
